// File: rtl/sport_pkg.sv
// Shared types and helpers for the SPORT receiver.
// State encoding and bit-counter sizing live here.
package sport_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  function automatic int cnt_w(input int w);
    return (w > 2) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/sport_lane_shift.sv
// One serial lane: WORD_W shift register with selectable insert end.
// word is the register contents including the bit on din this cycle.
module sport_lane_shift #(
  parameter int WORD_W    = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              sport_clk,
  input  logic              rst,
  input  logic              en,
  input  logic              clr,
  input  logic              din,
  output logic [WORD_W-1:0] word
);

  logic [WORD_W-1:0] q;

  generate
    if (MSB_FIRST) begin : g_msb
      assign word = {q[WORD_W-2:0], din};
    end else begin : g_lsb
      assign word = {din, q[WORD_W-1:1]};
    end
  endgenerate

  always_ff @(posedge sport_clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= word;
    end
  end

endmodule

// File: rtl/sport_rx_multi.sv
// Multi-lane SPORT receiver: frame FSM, bit counter,
// held output word with valid/ready and error pulses.
module sport_rx_multi
  import sport_pkg::*;
#(
  parameter int N_CH      = 4,
  parameter int WORD_W    = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit FS_ACTIVE = 1'b0
) (
  input  logic                   sport_clk,
  input  logic                   rst,
  input  logic [N_CH-1:0]        data,
  input  logic                   fs,
  output logic [N_CH*WORD_W-1:0] data_out,
  output logic                   valid,
  input  logic                   ready,
  output logic                   first,
  output logic                   overrun,
  output logic                   frame_err
);

  localparam int CW = cnt_w(WORD_W);
  localparam logic [CW-1:0] LAST = CW'(WORD_W - 1);

  state_e                 state;
  logic [CW-1:0]          bit_cnt;
  logic                   first_pend;
  logic [N_CH*WORD_W-1:0] word;
  logic                   fs_act;
  logic                   busy;
  logic                   clr;
  logic                   done;

  assign fs_act = (fs == FS_ACTIVE);
  assign busy   = (state == SHIFT);
  assign clr    = busy && !fs_act && (bit_cnt != '0);
  assign done   = busy && fs_act && (bit_cnt == LAST);

  generate
    for (genvar k = 0; k < N_CH; k++) begin : g_lane
      sport_lane_shift #(
        .WORD_W    (WORD_W),
        .MSB_FIRST (MSB_FIRST)
      ) u_lane (
        .sport_clk (sport_clk),
        .rst       (rst),
        .en        (fs_act),
        .clr       (clr),
        .din       (data[k]),
        .word      (word[k*WORD_W +: WORD_W])
      );
    end
  endgenerate

  always_ff @(posedge sport_clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      first_pend <= 1'b0;
      data_out   <= '0;
      valid      <= 1'b0;
      first      <= 1'b0;
      overrun    <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (fs_act) begin
            state      <= SHIFT;
            bit_cnt    <= CW'(1);
            first_pend <= 1'b1;
          end
        end
        SHIFT: begin
          if (!fs_act) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            frame_err <= (bit_cnt != '0);
          end else if (done) begin
            bit_cnt <= '0;
          end else begin
            bit_cnt <= bit_cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
      // A full output register with no taker drops the new word.
      if (done) begin
        first_pend <= 1'b0;
        if (!valid || ready) begin
          data_out <= word;
          first    <= first_pend;
          valid    <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sport_rx_multi.sv
// Scoreboard bench for sport_rx_multi: bit-level reference model
// feeds expected words and pulse cycles; a monitor pops and compares.
module tb_sport_rx_multi;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fs = 1'b1;
  logic [3:0]  data = '0;
  logic        ready = 1'b1;
  logic [31:0] data_out;
  logic        valid, first, overrun, frame_err;

  logic        fs2 = 1'b1;
  logic [1:0]  data2 = '0;
  logic [23:0] data_out2;
  logic        valid2, first2, overrun2, frame_err2;

  always #5 clk = ~clk;

  sport_rx_multi u_dut (
    .sport_clk (clk),
    .rst       (rst),
    .data      (data),
    .fs        (fs),
    .data_out  (data_out),
    .valid     (valid),
    .ready     (ready),
    .first     (first),
    .overrun   (overrun),
    .frame_err (frame_err)
  );

  sport_rx_multi #(
    .N_CH      (2),
    .WORD_W    (12),
    .MSB_FIRST (1'b0)
  ) u_dut12 (
    .sport_clk (clk),
    .rst       (rst),
    .data      (data2),
    .fs        (fs2),
    .data_out  (data_out2),
    .valid     (valid2),
    .ready     (1'b1),
    .first     (first2),
    .overrun   (overrun2),
    .frame_err (frame_err2)
  );

  typedef struct {
    logic [31:0] d;
    logic        f;
  } exp_t;

  exp_t exp_q[$];
  int   ovr_q[$];
  int   ferr_q[$];

  int n_cmp = 0;
  int n_bad = 0;
  int edge_n = 0;
  bit mon_on = 1'b0;

  bit in_frame = 1'b0;
  bit held = 1'b0;
  bit first_pend = 1'b0;
  bit exp_valid_now = 1'b0;
  int cnt = 0;
  int acc[4];

  always @(posedge clk) edge_n++;

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
    end
  endtask

  task automatic fail(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s got=unexpected exp=none t=%0t", nm, $time);
  endtask

  // Reference: words are built from bit history with plain arithmetic.
  task automatic model(input int e);
    bit fsa;
    bit done;
    logic [31:0] w;
    fsa  = (fs == 1'b0);
    done = 1'b0;
    exp_valid_now = held;
    if (!in_frame) begin
      if (fsa) begin
        in_frame   = 1'b1;
        cnt        = 1;
        first_pend = 1'b1;
        for (int k = 0; k < 4; k++) acc[k] = int'(data[k]);
      end
    end else if (fsa) begin
      for (int k = 0; k < 4; k++)
        acc[k] = (acc[k] * 2 + int'(data[k])) % 256;
      cnt++;
      if (cnt == 8) begin
        done = 1'b1;
        cnt  = 0;
      end
    end else begin
      if (cnt != 0) ferr_q.push_back(e);
      in_frame = 1'b0;
      cnt      = 0;
    end
    if (done) begin
      w = '0;
      for (int k = 0; k < 4; k++) w = w | (32'(acc[k]) << (8 * k));
      if (!held || ready) begin
        exp_q.push_back('{w, first_pend});
        held = 1'b1;
      end else begin
        ovr_q.push_back(e);
      end
      first_pend = 1'b0;
    end else if (held && ready) begin
      held = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    if (mon_on && !rst) begin
      exp_t e;
      chk("valid", 64'(valid), 64'(exp_valid_now));
      if (valid && ready) begin
        if (exp_q.size() == 0) begin
          fail("word_extra");
        end else begin
          e = exp_q.pop_front();
          chk("data_out", 64'(data_out), 64'(e.d));
          chk("first", 64'(first), 64'(e.f));
        end
      end
      if (overrun) begin
        if (ovr_q.size() == 0) fail("overrun_extra");
        else chk("overrun_cycle", 64'(edge_n), 64'(ovr_q.pop_front()));
      end else if (ovr_q.size() != 0 && ovr_q[0] == edge_n) begin
        chk("overrun_missing", 64'(0), 64'(1));
        void'(ovr_q.pop_front());
      end
      if (frame_err) begin
        if (ferr_q.size() == 0) fail("frame_err_extra");
        else chk("frame_err_cycle", 64'(edge_n), 64'(ferr_q.pop_front()));
      end else if (ferr_q.size() != 0 && ferr_q[0] == edge_n) begin
        chk("frame_err_missing", 64'(0), 64'(1));
        void'(ferr_q.pop_front());
      end
    end
  end

  task automatic step(input logic f, input logic [3:0] d, input int rm);
    @(posedge clk);
    #1;
    fs    = f;
    data  = d;
    ready = (rm == 2) ? ($urandom_range(0, 3) != 0) : rm[0];
    model(edge_n + 1);
  endtask

  task automatic send_word(input logic [31:0] w, input int rm);
    logic [3:0] d;
    for (int b = 0; b < 8; b++) begin
      for (int k = 0; k < 4; k++) d[k] = w[k*8 + 7 - b];
      step(1'b0, d, rm);
    end
  endtask

  task automatic idle(input int n, input int rm);
    for (int i = 0; i < n; i++) step(1'b1, 4'($urandom), rm);
  endtask

  task automatic partial(input int n, input int rm);
    for (int i = 0; i < n; i++) step(1'b0, 4'($urandom), rm);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_data_out"}, 64'(data_out), 64'(0));
    chk({tag, "_valid"}, 64'(valid), 64'(0));
    chk({tag, "_first"}, 64'(first), 64'(0));
    chk({tag, "_overrun"}, 64'(overrun), 64'(0));
    chk({tag, "_frame_err"}, 64'(frame_err), 64'(0));
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    fs  = 1'b1;
    ready = 1'b1;
    in_frame = 1'b0;
    held = 1'b0;
    first_pend = 1'b0;
    exp_valid_now = 1'b0;
    cnt = 0;
    exp_q.delete();
    ovr_q.delete();
    ferr_q.delete();
    #1;
    check_reset_vals("rst_mid");
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    logic [11:0] p;
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("rst_init");
    chk("rst_init_valid2", 64'(valid2), 64'(0));
    rst = 1'b0;
    mon_on = 1'b1;
    idle(3, 1);

    send_word(32'h01FF3CA5, 1);
    idle(4, 1);

    send_word(32'h12345678, 1);
    send_word(32'h9ABCDEF0, 1);
    send_word(32'h0F1E2D3C, 1);
    idle(3, 1);

    send_word(32'hDEADBEEF, 0);
    send_word(32'hCAFEF00D, 0);
    idle(3, 0);
    idle(4, 1);

    partial(5, 1);
    idle(3, 1);
    send_word(32'h55AA33CC, 1);
    idle(3, 1);

    partial(4, 1);
    pulse_reset();
    idle(2, 1);
    send_word(32'h80402010, 1);
    idle(3, 1);

    for (int f = 0; f < 40; f++) begin
      int nw;
      nw = $urandom_range(1, 3);
      for (int i = 0; i < nw; i++) send_word($urandom, 2);
      if ($urandom_range(0, 3) == 0) partial($urandom_range(1, 7), 2);
      idle($urandom_range(1, 4), 2);
    end
    idle(6, 1);

    p = 12'($urandom);
    for (int i = 0; i < 12; i++) begin
      fs2   = 1'b0;
      data2 = {p[i], (i == 0)};
      step(1'b1, 4'h0, 1);
    end
    fs2 = 1'b1;
    @(negedge clk);
    chk("w12_valid", 64'(valid2), 64'(1));
    chk("w12_ch0", 64'(data_out2[11:0]), 64'h001);
    chk("w12_ch1", 64'(data_out2[23:12]), 64'(p));
    chk("w12_first", 64'(first2), 64'(1));
    chk("w12_errs", 64'({overrun2, frame_err2}), 64'(0));
    idle(2, 1);
    @(negedge clk);
    chk("w12_valid_drop", 64'(valid2), 64'(0));

    idle(3, 1);
    mon_on = 1'b0;
    chk("exp_q_empty", 64'(exp_q.size()), 64'(0));
    chk("ovr_q_empty", 64'(ovr_q.size()), 64'(0));
    chk("ferr_q_empty", 64'(ferr_q.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sport_rx_multi.md
# sport_rx_multi

Parametrised SPORT serial receiver: deserialises N_CH parallel data lines framed by a frame-sync level into WORD_W-bit words. It supports back-to-back words within one frame, selectable bit order, a valid/ready output handshake, and error reporting. It sits between the external SPORT pins (sampled in the sport_clk domain) and the downstream frame/ADC-data consumers, replacing the fixed 4×8-bit receiver.

## Interface
- N_CH, 4, number of serial data lines (≥1)
- WORD_W, 8, bits per word per line (≥2)
- MSB_FIRST, 1, 1: first received bit lands in bit WORD_W-1; 0: first bit lands in bit 0
- FS_ACTIVE, 0, level of fs that marks an active frame
- sport_clk  in  1  serial bit clock; all logic on its rising edge. One clock; reset is asynchronous and active-high.
- rst  in  1  asynchronous, active-high reset
- data  in  N_CH  serial bits, line k → channel k
- fs  in  1  frame sync level; active when fs == FS_ACTIVE
- data_out  out  N_CH*WORD_W  held word; channel k in bits [k*WORD_W +: WORD_W]
- valid  out  1  data_out holds an unconsumed word
- ready  in  1  consumer accepts data_out on an edge where valid && ready
- first  out  1  qualifies data_out: word was the first of its frame
- overrun  out  1  one-cycle pulse: completed word dropped because output was full
- frame_err  out  1  one-cycle pulse: fs went inactive mid-word

## Operation
- States: IDLE, SHIFT (encoding in sport_pkg).
- IDLE: on an edge with fs active, sample bit 0 of every lane, set bit_cnt = 1, set first_pending = 1, go to SHIFT.
- SHIFT, fs active: sample one bit per lane, increment bit_cnt.
- Word completion: on the edge sampling bit WORD_W-1 (bit_cnt == WORD_W-1), the full word (shift contents plus the current bit) is the completed word. bit_cnt wraps to 0 and the block stays in SHIFT. The next word starts on the following edge with no gap.
- SHIFT, fs inactive, bit_cnt == 0: go to IDLE with no error.
- SHIFT, fs inactive, bit_cnt ≠ 0: discard the partial word, pulse frame_err, go to IDLE.
- Bit order: MSB_FIRST=1 shifts left, inserting at bit 0. MSB_FIRST=0 shifts right, inserting at bit WORD_W-1.
- Output register load rules at word completion:
  - valid == 0: load data_out and first ← first_pending, set valid, clear first_pending.
  - valid == 1 && ready: accept the old word and load the new one; valid stays 1.
  - valid == 1 && !ready: drop the new word, keep the held word, pulse overrun. first_pending is still cleared.
- Without completion, valid && ready clears valid. data_out holds its last value.
- bit_cnt width: $clog2(WORD_W). No arithmetic beyond the increment/wrap.

## Timing
- Reset values: state IDLE, bit_cnt 0, shift registers 0, data_out 0, valid 0, first 0, overrun 0, frame_err 0.
- Latency: valid and data_out update on the same edge that samples the last bit, so they are visible 1 cycle after the last bit's set-up.
- Throughput: one word per WORD_W clocks, sustained, provided ready is high at each completion.
- overrun and frame_err are high for exactly one cycle, in the cycle after the offending edge.
- Reset asserted mid-word or mid-frame: everything clears immediately. After release, reception restarts only on an IDLE-state edge with fs active. A frame already in progress therefore resynchronises at its current bit, which is acceptable and documented.
- fs and data are sampled on the same edge; there are no set-up requirements beyond sport_clk timing.

## Structure
- sport_pkg holds:
  - state enum (IDLE, SHIFT)
  - a function computing the bit-counter width from WORD_W
- Sub-module sport_lane_shift: one WORD_W shift register with MSB_FIRST insertion, shift-enable and clear. Instantiate N_CH copies with generate.
- The top level holds the FSM, bit counter, output register and handshake.

## Test plan
- Default parameters: fs=0 for 8 clocks, lanes 0–3 carry 0xA5, 0x3C, 0xFF, 0x01 MSB first, ready=1. Expect:
  - data_out = 0x01FF3CA5
  - valid for 1 cycle after bit 7
  - first=1
  - no error pulses
- fs held for 24 clocks (3 words), ready=1. Expect three valid words on consecutive 8-cycle boundaries, first=1 only on the first, no gaps.
- ready=0 across two completions. Expect the first word held unchanged, one overrun pulse at the second completion, and valid to drop one cycle after ready rises.
- fs deasserted after 5 bits. Expect a frame_err pulse, valid stays 0, and the next full frame decodes correctly.
- MSB_FIRST=0, N_CH=2, WORD_W=12: send bits 1,0,0,…,0 on lane 0. Expect channel 0 = 0x001.
- rst pulsed at bit 4. Expect all outputs to return to reset values immediately, and a later frame to be received intact.
